// File: rtl/sr_drv_pkg.sv
// Shared types and constants for the SR latch driver.
package sr_drv_pkg;

  // Command sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_t;

  localparam int DEF_PULSE_CYCLES  = 4;
  localparam int DEF_SETTLE_CYCLES = 2;

  // Width needed to hold the larger of the two phase lengths
  function automatic int cnt_width(input int pulse_cycles, input int settle_cycles);
    int max_cnt;
    max_cnt = (pulse_cycles > settle_cycles) ? pulse_cycles : settle_cycles;
    if (max_cnt < 1) max_cnt = 1;
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops give metastability time to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// Command-side controller for an external NOR SR latch: issues a fixed-width
// set/reset pulse, waits for the latch to settle, then checks the readback.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYCLES  = DEF_PULSE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_value,
  output logic cmd_ready,
  output logic set_out,
  output logic reset_out,
  input  logic q_in,
  input  logic qnot_in,
  output logic done,
  output logic fault,
  output logic state_q
);

  localparam int CNT_W = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  // Reject parameter values that would break the pulse/settle timing
  generate
    if (PULSE_CYCLES < 1) begin : g_bad_pulse
      $error("sr_latch_driver: PULSE_CYCLES must be >= 1");
    end
    if (SETTLE_CYCLES < 2) begin : g_bad_settle
      $error("sr_latch_driver: SETTLE_CYCLES must be >= 2");
    end
  endgenerate

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             val_reg, val_next;
  logic             fault_next, state_q_next;
  logic             set_next, reset_next, done_next, ready_next;
  logic             q_sync, qnot_sync;

  sync2 u_sync_q (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_in),
    .q     (q_sync)
  );

  sync2 u_sync_qnot (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (qnot_in),
    .q     (qnot_sync)
  );

  // Next-state, counter and registered-output decode
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    val_next     = val_reg;
    fault_next   = fault;
    state_q_next = state_q;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          val_next   = cmd_value;
          fault_next = 1'b0;
          cnt_next   = PULSE_LOAD;
          state_next = PULSE;
        end
      end
      PULSE: begin
        if (cnt_reg == '0) begin
          cnt_next   = SETTLE_LOAD;
          state_next = SETTLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt_reg == '0) begin
          state_next = CHECK;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      CHECK: begin
        // Both rails must agree with the requested value for a pass
        if ((q_sync == val_reg) && (qnot_sync == ~val_reg)) begin
          state_q_next = val_reg;
        end else begin
          fault_next = 1'b1;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Outputs are decoded from the upcoming state so they can be registered
    // without adding a cycle of latency; only one drive can ever be high.
    set_next   = (state_next == PULSE) &  val_next;
    reset_next = (state_next == PULSE) & ~val_next;
    done_next  = (state_next == CHECK);
    ready_next = (state_next == IDLE);
  end

  // State and output registers; async reset drops the drives immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      val_reg   <= 1'b0;
      set_out   <= 1'b0;
      reset_out <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
      fault     <= 1'b0;
      state_q   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      val_reg   <= val_next;
      set_out   <= set_next;
      reset_out <= reset_next;
      done      <= done_next;
      cmd_ready <= ready_next;
      fault     <= fault_next;
      state_q   <= state_q_next;
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench: two drivers (default timing and 1/2 timing), each wrapped around a
// behavioural NOR latch with a selectable Q stuck-at-0 fault.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: default parameters
  logic cmd_valid_a, cmd_value_a, cmd_ready_a, set_a, reset_a;
  logic q_a, qnot_a, done_a, fault_a, state_q_a;
  logic lat_a = 1'b0;
  logic stuck_a;

  // Instance B: PULSE_CYCLES=1, SETTLE_CYCLES=2
  logic cmd_valid_b, cmd_value_b, cmd_ready_b, set_b, reset_b;
  logic q_b, qnot_b, done_b, fault_b, state_q_b;
  logic lat_b = 1'b0;
  logic stuck_b;

  int checks = 0;
  int errors = 0;

  sr_latch_driver dut_a (
    .clk (clk), .rst_n (rst_n),
    .cmd_valid (cmd_valid_a), .cmd_value (cmd_value_a), .cmd_ready (cmd_ready_a),
    .set_out (set_a), .reset_out (reset_a),
    .q_in (q_a), .qnot_in (qnot_a),
    .done (done_a), .fault (fault_a), .state_q (state_q_a)
  );

  sr_latch_driver #(.PULSE_CYCLES(1), .SETTLE_CYCLES(2)) dut_b (
    .clk (clk), .rst_n (rst_n),
    .cmd_valid (cmd_valid_b), .cmd_value (cmd_value_b), .cmd_ready (cmd_ready_b),
    .set_out (set_b), .reset_out (reset_b),
    .q_in (q_b), .qnot_in (qnot_b),
    .done (done_b), .fault (fault_b), .state_q (state_q_b)
  );

  // Behavioural NOR latches: set wins on set, reset wins on reset
  always @(posedge set_a or posedge reset_a) begin
    if (set_a) lat_a <= 1'b1;
    else       lat_a <= 1'b0;
  end
  assign q_a    = stuck_a ? 1'b0 : lat_a;
  assign qnot_a = ~lat_a;

  always @(posedge set_b or posedge reset_b) begin
    if (set_b) lat_b <= 1'b1;
    else       lat_b <= 1'b0;
  end
  assign q_b    = stuck_b ? 1'b0 : lat_b;
  assign qnot_b = ~lat_b;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drives must never both be high, in any cycle, on either instance
  always @(negedge clk) begin
    checks++;
    if ((set_a & reset_a) | (set_b & reset_b)) begin
      errors++;
      $display("FAIL drive_overlap: a=%b%b b=%b%b required no overlap", set_a, reset_a, set_b, reset_b);
    end
  end

  function automatic logic [3:0] exp_vec(input int k, input int p, input int t, input logic v);
    return {v & (k <= p), ~v & (k <= p), (k == t - 1), (k == t)};
  endfunction

  // Issue one command at the current negedge and check every cycle of it
  task automatic do_cmd(input int idx, input int sel, input logic v, input logic stuck,
                        input logic exp_fault, input logic exp_sq);
    int p;
    int t;
    logic [3:0] obs;
    p = (sel == 0) ? 4 : 1;
    t = p + 2 + 2;
    if (sel == 0) begin
      cmd_valid_a = 1'b1; cmd_value_a = v; stuck_a = stuck;
    end else begin
      cmd_valid_b = 1'b1; cmd_value_b = v; stuck_b = stuck;
    end
    @(posedge clk);
    #1;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_value_a = ~v;   cmd_value_b = ~v;
    for (int k = 1; k <= t; k++) begin
      @(negedge clk);
      obs = (sel == 0) ? {set_a, reset_a, done_a, cmd_ready_a}
                       : {set_b, reset_b, done_b, cmd_ready_b};
      chk($sformatf("cmd%0d_cyc%0d_srdr", idx, k), obs, exp_vec(k, p, t, v));
      if (k == 1)
        chk($sformatf("cmd%0d_fault_clear", idx), {3'b0, (sel == 0) ? fault_a : fault_b}, 4'b0);
      if (k == t) begin
        chk($sformatf("cmd%0d_fault", idx), {3'b0, (sel == 0) ? fault_a : fault_b}, {3'b0, exp_fault});
        chk($sformatf("cmd%0d_state_q", idx), {3'b0, (sel == 0) ? state_q_a : state_q_b}, {3'b0, exp_sq});
      end
    end
    $display("cmd %0d inst %s value %0b stuck %0b -> fault %0b state_q %0b", idx,
             (sel == 0) ? "A" : "B", v, stuck,
             (sel == 0) ? fault_a : fault_b, (sel == 0) ? state_q_a : state_q_b);
  endtask

  typedef struct {
    int   sel;
    logic v;
    logic stuck;
    logic exp_fault;
    logic exp_sq;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] vals;
    int dones;
    int k;
    int n;

    vecs[0] = '{0, 1'b1, 1'b0, 1'b0, 1'b1};  // set, good latch
    vecs[1] = '{0, 1'b0, 1'b0, 1'b0, 1'b0};  // reset, good latch
    vecs[2] = '{0, 1'b1, 1'b1, 1'b1, 1'b0};  // set, Q stuck at 0 -> fault
    vecs[3] = '{0, 1'b0, 1'b0, 1'b0, 1'b0};  // next command clears fault
    vecs[4] = '{0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{0, 1'b1, 1'b0, 1'b0, 1'b1};  // repeat set still pulses
    vecs[6] = '{1, 1'b1, 1'b0, 1'b0, 1'b1};  // short-pulse instance
    vecs[7] = '{1, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    cmd_valid_a = 1'b0; cmd_value_a = 1'b0; stuck_a = 1'b0;
    cmd_valid_b = 1'b0; cmd_value_b = 1'b0; stuck_b = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_a_srdr", {set_a, reset_a, done_a, cmd_ready_a}, 4'b0001);
    chk("rst_a_fault_sq", {2'b0, fault_a, state_q_a}, 4'b0);
    chk("rst_b_srdr", {set_b, reset_b, done_b, cmd_ready_b}, 4'b0001);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_a_srdr", {set_a, reset_a, done_a, cmd_ready_a}, 4'b0001);
    chk("post_rst_b_fault_sq", {2'b0, fault_b, state_q_b}, 4'b0);

    for (int i = 0; i < 8; i++)
      do_cmd(i, vecs[i].sel, vecs[i].v, vecs[i].stuck, vecs[i].exp_fault, vecs[i].exp_sq);

    // cmd_valid held high on A, value alternating per command, noise between
    vals = 3'b010;  // command 0 = 0, command 1 = 1, command 2 = 0
    dones = 0;
    cmd_valid_a = 1'b1;
    cmd_value_a = vals[0];
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      k = ((c - 1) % 8) + 1;
      n = (c - 1) / 8;
      chk($sformatf("held_c%0d_srdr", c), {set_a, reset_a, done_a, cmd_ready_a},
          exp_vec(k, 4, 8, vals[n]));
      if (done_a) dones++;
      if (k == 8) begin
        chk($sformatf("held_cmd%0d_state_q", n), {3'b0, state_q_a}, {3'b0, vals[n]});
        $display("held cmd %0d value %0b -> state_q %0b", n, vals[n], state_q_a);
        if (n < 2) cmd_value_a = vals[n + 1];
        else       cmd_valid_a = 1'b0;
      end else begin
        cmd_value_a = 1'($urandom_range(0, 1));
      end
    end
    chk("held_done_count", 4'(dones), 4'd3);

    // Asynchronous reset during the second pulse cycle
    cmd_valid_a = 1'b1; cmd_value_a = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid_a = 1'b0;
    @(negedge clk);
    chk("abort_cyc1_set", {3'b0, set_a}, 4'b0001);
    @(negedge clk);
    chk("abort_cyc2_set", {3'b0, set_a}, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async_drop", {set_a, reset_a, done_a, cmd_ready_a}, 4'b0001);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk($sformatf("abort_after_c%0d", c), {set_a, reset_a, done_a, cmd_ready_a}, 4'b0001);
    end
    chk("abort_state_q", {2'b0, fault_a, state_q_a}, 4'b0);
    $display("abort: reset mid-pulse, no done, state_q %0b", state_q_a);

    // Normal operation resumes after the abort
    do_cmd(8, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
